// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: immediate format selector, opcode constants and
// the instruction packer/legality checker used by the encoder and by benches.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_I  = 3'd0,
    FMT_S  = 3'd1,
    FMT_SB = 3'd2,
    FMT_U  = 3'd3,
    FMT_R  = 3'd4
  } imm_fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef struct packed {
    logic        legal;
    logic [31:0] instr;
  } enc_t;

  // Packs the fields for the given format and reports whether the immediate
  // is representable. Format codes 5-7 are never legal.
  function automatic enc_t encode_instr(
    input logic [2:0]  fmt,
    input logic [6:0]  opcode,
    input logic [2:0]  funct3,
    input logic [6:0]  funct7,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    enc_t r;
    r.legal = 1'b0;
    r.instr = '0;
    case (fmt)
      FMT_I: begin
        r.instr = {imm[11:0], rs1, funct3, rd, opcode};
        r.legal = (imm[31:11] == '0) || (imm[31:11] == '1);
      end
      FMT_S: begin
        r.instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        r.legal = (imm[31:11] == '0) || (imm[31:11] == '1);
      end
      FMT_SB: begin
        r.instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        r.legal = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];
      end
      FMT_U: begin
        // Same bit scramble the core's U/J extender undoes.
        r.instr = {imm[31], imm[21:12], imm[22], imm[30:23], rd, opcode};
        r.legal = (imm[11:0] == '0);
      end
      FMT_R: begin
        r.instr = {funct7, rs2, rs1, funct3, rd, opcode};
        r.legal = 1'b1;
      end
      default: begin
        r.instr = '0;
        r.legal = 1'b0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Two-entry synchronous FIFO (EMPTY/ONE/FULL). Slot 0 is always the head;
// no same-cycle pass-through from push to output.
module enc_fifo2 #(
  parameter int                 DATA_W  = 44,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              valid,
  output logic [DATA_W-1:0] head
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] slot0_q, slot0_d;
  logic [DATA_W-1:0] slot1_q, slot1_d;
  logic              push_ok, pop_ok;

  // Next-state and slot updates; pushes while FULL and pops while EMPTY are ignored.
  always_comb begin
    push_ok = push && (state_q != ST_FULL);
    pop_ok  = pop && (state_q != ST_EMPTY);
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    case (state_q)
      ST_EMPTY: begin
        if (push_ok) begin
          slot0_d = push_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push_ok && pop_ok) begin
          slot0_d = push_data;
        end else if (push_ok) begin
          slot1_d = push_data;
          state_d = ST_FULL;
        end else if (pop_ok) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop_ok) begin
          slot0_d = slot1_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State and head register; reset discards contents and shows the reset word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      slot0_q <= RST_VAL;
    end else begin
      state_q <= state_d;
      slot0_q <= slot0_d;
    end
  end

  // Second slot holds data only; its content is meaningless unless FULL.
  always_ff @(posedge clk) begin
    slot1_q <= slot1_d;
  end

  assign full  = (state_q == ST_FULL);
  assign valid = (state_q != ST_EMPTY);
  assign head  = slot0_q;

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder: packs and range-checks requests,
// tags legal words with a sequential byte address and buffers them in a
// 2-entry FIFO. Dropped (illegal) requests are counted.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              addr_clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_sticky,
  output logic [7:0]        err_count
);

  localparam int FIFO_W = 32 + ADDR_W;

  enc_t              enc;
  logic              accept;
  logic              push;
  logic              fifo_full;
  logic [FIFO_W-1:0] fifo_head;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_sticky_q, err_sticky_d;
  logic [7:0]        err_count_q, err_count_d;

  // Pack the request, decide whether it is pushed or dropped, and compute
  // the next address and error state. A clear overrides the increment.
  always_comb begin
    enc          = encode_instr(in_fmt, in_opcode, in_funct3, in_funct7,
                                in_rd, in_rs1, in_rs2, in_imm);
    accept       = in_valid && in_ready;
    push         = accept && enc.legal;
    addr_d       = addr_q;
    err_sticky_d = err_sticky_q;
    err_count_d  = err_count_q;
    if (addr_clear) begin
      addr_d = BASE_ADDR;
    end else if (push) begin
      addr_d = addr_q + ADDR_W'(4);
    end
    if (accept && !enc.legal) begin
      err_sticky_d = 1'b1;
      if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
  end

  // Address counter and error bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q       <= BASE_ADDR;
      err_sticky_q <= 1'b0;
      err_count_q  <= 8'd0;
    end else begin
      addr_q       <= addr_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
    end
  end

  enc_fifo2 #(
    .DATA_W  (FIFO_W),
    .RST_VAL ({32'h0, BASE_ADDR})
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({enc.instr, addr_q}),
    .pop       (out_ready),
    .full      (fifo_full),
    .valid     (out_valid),
    .head      (fifo_head)
  );

  assign in_ready   = !reset && !fifo_full;
  assign out_instr  = fifo_head[FIFO_W-1:ADDR_W];
  assign out_addr   = fifo_head[ADDR_W-1:0];
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: known encodings, streaming, drops,
// backpressure, address wrap/clear, round-trip decode and mid-stream reset.
module tb_instr_encoder;
  import riscv_pkg::*;

  localparam logic [11:0] B = 12'h100;

  logic        clk = 1'b0;
  logic        reset, in_valid, addr_clear, out_ready;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;

  logic        in_ready, out_valid, err_sticky;
  logic [31:0] out_instr;
  logic [11:0] out_addr;
  logic [7:0]  err_count;

  logic        in_ready4, out_valid4, err_sticky4;
  logic [31:0] out_instr4;
  logic [3:0]  out_addr4;
  logic [7:0]  err_count4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(12), .BASE_ADDR(B)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .addr_clear(addr_clear), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .err_sticky(err_sticky), .err_count(err_count)
  );

  instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'h0)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .addr_clear(addr_clear), .out_valid(out_valid4),
    .out_ready(out_ready), .out_instr(out_instr4), .out_addr(out_addr4),
    .err_sticky(err_sticky4), .err_count(err_count4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [31:0] imm);
    in_valid  = 1'b1;
    in_fmt    = f;
    in_opcode = op;
    in_funct3 = f3;
    in_funct7 = f7;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
  endtask

  task automatic addi(input logic [31:0] k);
    req(FMT_I, OP_OPIMM, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, k);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; addr_clear = 1'b0; out_ready = 1'b1;
    req(FMT_R, OP_OP, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    in_valid = 1'b0;
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL rst_out_instr got %h exp 0", out_instr); end
    checks++; if (out_addr !== B) begin errors++; $display("FAIL rst_out_addr got %h exp %h", out_addr, B); end
    checks++; if (err_sticky !== 1'b0 || err_count !== 8'd0) begin errors++; $display("FAIL rst_err got %b/%0d exp 0/0", err_sticky, err_count); end
    checks++; if ({in_ready4, out_valid4, err_sticky4, err_count4, out_instr4, out_addr4} !== '0) begin errors++; $display("FAIL rst_dut4 got nonzero exp zero"); end
    reset = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_ready got %b/%b exp 1/0", in_ready, out_valid); end
  endtask

  task automatic test_lw();
    req(FMT_I, OP_LOAD, 3'b010, 7'd0, 5'd5, 5'd2, 5'd0, 32'hFFFFFFFC);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'hFFC12283) begin errors++; $display("FAIL lw_instr got %b/%h exp 1/ffc12283", out_valid, out_instr); end
    checks++; if (out_addr !== B) begin errors++; $display("FAIL lw_addr got %h exp %h", out_addr, B); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lw_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    req(FMT_S, OP_STORE, 3'b010, 7'd0, 5'd0, 5'd2, 5'd5, 32'd8);
    tick();
    checks++; if (out_instr !== 32'h00512423 || out_addr !== B + 12'd4) begin errors++; $display("FAIL sw_word got %h@%h exp 00512423@%h", out_instr, out_addr, B + 12'd4); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", in_ready); end
    req(FMT_SB, OP_BRANCH, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'hFE208CE3 || out_addr !== B + 12'd8) begin errors++; $display("FAIL beq_word got %h@%h exp fe208ce3@%h", out_instr, out_addr, B + 12'd8); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_illegal();
    req(FMT_I, OP_OPIMM, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    tick();
    checks++; if (err_count !== 8'd1 || err_sticky !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL drop_i got cnt %0d st %b v %b exp 1 1 0", err_count, err_sticky, out_valid); end
    req(FMT_SB, OP_BRANCH, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'd5);
    tick();
    req(FMT_U, OP_LUI, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00000800);
    tick();
    req(3'd6, OP_OP, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
    tick();
    in_valid = 1'b0;
    checks++; if (err_count !== 8'd4 || out_valid !== 1'b0) begin errors++; $display("FAIL drop_all got cnt %0d v %b exp 4 0", err_count, out_valid); end
    req(FMT_SB, OP_BRANCH, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'd6);
    tick();
    checks++; if (out_instr !== 32'h00208363 || out_addr !== B + 12'd12) begin errors++; $display("FAIL sb6_word got %h@%h exp 00208363@%h", out_instr, out_addr, B + 12'd12); end
    addi(32'hFFFFF800);
    tick();
    checks++; if (out_instr !== 32'h80000093 || out_addr !== B + 12'd16) begin errors++; $display("FAIL imin_word got %h@%h exp 80000093@%h", out_instr, out_addr, B + 12'd16); end
    req(FMT_R, OP_OP, 3'b000, 7'd0, 5'd3, 5'd1, 5'd2, 32'hDEADBEEF);
    tick();
    in_valid = 1'b0;
    checks++; if (out_instr !== 32'h002081B3 || out_addr !== B + 12'd20) begin errors++; $display("FAIL r_word got %h@%h exp 002081b3@%h", out_instr, out_addr, B + 12'd20); end
    tick();
    checks++; if (err_count !== 8'd4) begin errors++; $display("FAIL drop_hold got %0d exp 4", err_count); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    addi(32'd1);
    tick();
    checks++; if (in_ready !== 1'b1 || out_instr !== 32'h00100093 || out_addr !== B + 12'd24) begin errors++; $display("FAIL bp_w1 got %b %h@%h exp 1 00100093@%h", in_ready, out_instr, out_addr, B + 12'd24); end
    addi(32'd2);
    tick();
    checks++; if (in_ready !== 1'b0 || out_instr !== 32'h00100093) begin errors++; $display("FAIL bp_full got %b %h exp 0 00100093", in_ready, out_instr); end
    addi(32'd3);
    tick();
    checks++; if (in_ready !== 1'b0 || out_instr !== 32'h00100093 || out_addr !== B + 12'd24) begin errors++; $display("FAIL bp_hold got %b %h@%h exp 0 00100093@%h", in_ready, out_instr, out_addr, B + 12'd24); end
    out_ready = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1 || out_instr !== 32'h00200093 || out_addr !== B + 12'd28) begin errors++; $display("FAIL bp_w2 got %b %h@%h exp 1 00200093@%h", in_ready, out_instr, out_addr, B + 12'd28); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h00300093 || out_addr !== B + 12'd32) begin errors++; $display("FAIL bp_w3 got %b %h@%h exp 1 00300093@%h", out_valid, out_instr, out_addr, B + 12'd32); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_wrap_clear();
    in_valid = 1'b0; addr_clear = 1'b1;
    tick();
    addr_clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      addi(32'(i));
      tick();
      checks++;
      if (out_addr4 !== 4'(4 * i) || out_addr !== B + 12'(4 * i) || out_instr4 !== out_instr) begin
        errors++; $display("FAIL wrap_%0d got %h/%h exp %h/%h", i, out_addr4, out_addr, 4'(4 * i), B + 12'(4 * i));
      end
    end
    in_valid = 1'b0; addr_clear = 1'b1;
    tick();
    addr_clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addi(32'(i));
      addr_clear = (i == 2);
      tick();
      addr_clear = 1'b0;
      checks++;
      if (out_addr !== ((i < 3) ? B + 12'(4 * i) : B) || out_addr4 !== ((i < 3) ? 4'(4 * i) : 4'h0)) begin
        errors++; $display("FAIL clear_%0d got %h/%h", i, out_addr, out_addr4);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_round_trip();
    logic [31:0] r, imm, dec;
    logic [2:0]  f;
    logic [6:0]  op, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] exp_addr;
    logic        ok;
    in_valid = 1'b0; addr_clear = 1'b1; out_ready = 1'b1;
    tick();
    addr_clear = 1'b0;
    exp_addr = B;
    for (int n = 0; n < 10000; n++) begin
      f = 3'($urandom_range(0, 4));
      r = $urandom;
      op = 7'($urandom); f3 = 3'($urandom); f7 = 7'($urandom);
      rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      case (f)
        3'd0, 3'd1: imm = {{20{r[11]}}, r[11:0]};
        3'd2:       imm = {{19{r[12]}}, r[12:1], 1'b0};
        3'd3:       imm = {r[31:12], 12'h000};
        default:    imm = r;
      endcase
      req(f, op, f3, f7, rd, rs1, rs2, imm);
      tick();
      case (f)
        3'd0:    dec = {{20{out_instr[31]}}, out_instr[31:20]};
        3'd1:    dec = {{20{out_instr[31]}}, out_instr[31:25], out_instr[11:7]};
        3'd2:    dec = {{19{out_instr[31]}}, out_instr[31], out_instr[7], out_instr[30:25], out_instr[11:8], 1'b0};
        3'd3:    dec = {out_instr[31], out_instr[19:12], out_instr[20], out_instr[30:21], 12'h000};
        default: dec = imm;
      endcase
      ok = out_valid && (dec == imm) && (out_instr[6:0] == op) && (out_addr == exp_addr);
      if (f == 3'd4) ok = ok && (out_instr[31:7] == {f7, rs2, rs1, f3, rd});
      checks++;
      if (!ok) begin
        errors++;
        if (errors < 10) $display("FAIL roundtrip_%0d fmt %0d got %h@%h dec %h exp imm %h@%h", n, f, out_instr, out_addr, dec, imm, exp_addr);
      end
      exp_addr = exp_addr + 12'd4;
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_err_saturate();
    for (int i = 0; i < 260; i++) begin
      req(3'd7, OP_OP, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
      tick();
    end
    in_valid = 1'b0;
    tick();
    checks++; if (err_count !== 8'd255 || err_sticky !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL err_sat got %0d %b %b exp 255 1 0", err_count, err_sticky, out_valid); end
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    addi(32'd7);
    tick();
    addi(32'd8);
    tick();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL rf_full got %b/%b exp 0/1", in_ready, out_valid); end
    addi(32'd9);
    reset = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_instr !== 32'h0 || out_addr !== B) begin errors++; $display("FAIL rf_rst got %b %b %h@%h exp 0 0 0@%h", out_valid, in_ready, out_instr, out_addr, B); end
    checks++; if (err_count !== 8'd0 || err_sticky !== 1'b0) begin errors++; $display("FAIL rf_err got %0d %b exp 0 0", err_count, err_sticky); end
    reset = 1'b0;
    out_ready = 1'b1;
    addi(32'd10);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h00A00093 || out_addr !== B) begin errors++; $display("FAIL rf_first got %b %h@%h exp 1 00a00093@%h", out_valid, out_instr, out_addr, B); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_back_to_back();
    test_illegal();
    test_backpressure();
    test_wrap_clear();
    test_round_trip();
    test_err_saturate();
    test_reset_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
